// File: rtl/fifo_sc_pkg.sv
// Shared defaults and helpers for the single-clock FIFO.
// Default build leaves the water-level ports out; define FIFO_WATER_LEVEL_EN to add them.
package fifo_sc_pkg;

  localparam int FIFO_ADDR_WIDTH = 9;
  localparam int FIFO_DATA_WIDTH = 8;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  localparam int FIFO_DEPTH = fifo_depth(FIFO_ADDR_WIDTH);

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  typedef logic [FIFO_ADDR_WIDTH:0] ptr_t;

endpackage

// File: rtl/fifo_sc_ram.sv
// Simple dual-port RAM: synchronous write, registered read with read enable.
// The read register resets to zero; the array itself is never cleared.
module fifo_sc_ram
  import fifo_sc_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Holding the register when no read is accepted keeps the last word visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_sc_512x8.sv
// Single-clock FIFO (512x8 by default) with registered full/empty/almost flags.
// Optional FIFO_WATER_LEVEL_EN adds wr_water_level/rd_water_level occupancy outputs.
module fifo_sc_512x8
  import fifo_sc_pkg::*;
#(
  parameter int ADDR_WIDTH       = FIFO_ADDR_WIDTH,
  parameter int DATA_WIDTH       = FIFO_DATA_WIDTH,
  parameter int OUT_REG          = 0,
  parameter int ALMOST_FULL_NUM  = 380,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  almost_empty
`ifdef FIFO_WATER_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   wr_water_level,
  output logic [ADDR_WIDTH:0]   rd_water_level
`endif
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   occ_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  afull_q, afull_d;
  logic                  aempty_q, aempty_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  // Acceptance uses the registered flags, i.e. the state before the edge.
  assign wr_acc = wr_en && !full_q;
  assign rd_acc = rd_en && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    occ_d    = wr_ptr_d - rd_ptr_d;
    full_d   = (int'(occ_d) == DEPTH);
    empty_d  = (int'(occ_d) == 0);
    afull_d  = (int'(occ_d) >= ALMOST_FULL_NUM);
    aempty_d = (int'(occ_d) <= ALMOST_EMPTY_NUM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  fifo_sc_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wr_data_i (wr_data),
    .rd_en_i   (rd_acc),
    .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data_o (ram_rd_data)
  );

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] out_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_q <= '0;
        end else begin
          out_q <= ram_rd_data;
        end
      end
      assign rd_data = out_q;
    end else begin : g_no_out_reg
      assign rd_data = ram_rd_data;
    end
  endgenerate

`ifdef FIFO_WATER_LEVEL_EN
  logic [ADDR_WIDTH:0] level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
    end else begin
      level_q <= occ_d;
    end
  end

  assign wr_water_level = level_q;
  assign rd_water_level = level_q;
`endif

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;

endmodule

// File: tb/tb_fifo_sc_512x8.sv
// Bench for fifo_sc_512x8: directed and random traffic checked against a queue model.
// Also covers the water-level ports when FIFO_WATER_LEVEL_EN is defined.
module tb_fifo_sc_512x8;

  localparam int DEPTH = 512;
  localparam int AFN   = 380;
  localparam int AEN   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       full, almost_full, empty, almost_empty;
  logic [7:0] rd_data;
`ifdef FIFO_WATER_LEVEL_EN
  logic [9:0] wr_water_level, rd_water_level;
`endif

  int errors = 0;
  int checks = 0;

  byte unsigned model_q[$];
  logic [7:0]   exp_rd = '0;

  fifo_sc_512x8 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .full         (full),
    .almost_full  (almost_full),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .empty        (empty),
    .almost_empty (almost_empty)
`ifdef FIFO_WATER_LEVEL_EN
    ,
    .wr_water_level (wr_water_level),
    .rd_water_level (rd_water_level)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    int sz;
    sz = model_q.size();
    chk("empty",        32'(empty),        32'(sz == 0));
    chk("full",         32'(full),         32'(sz == DEPTH));
    chk("almost_full",  32'(almost_full),  32'(sz >= AFN));
    chk("almost_empty", 32'(almost_empty), 32'(sz <= AEN));
    chk("rd_data",      32'(rd_data),      32'(exp_rd));
`ifdef FIFO_WATER_LEVEL_EN
    chk("wr_water_level", 32'(wr_water_level), 32'(sz));
    chk("rd_water_level", 32'(rd_water_level), 32'(sz));
`endif
  endtask

  // Drive one cycle, advance the model using the pre-edge occupancy, then check.
  task automatic step(input bit we, input logic [7:0] wd, input bit re);
    bit wa, ra;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    wa = we && (model_q.size() != DEPTH);
    ra = re && (model_q.size() != 0);
    @(posedge clk);
    #1;
    if (ra) exp_rd = model_q.pop_front();
    if (wa) model_q.push_back(wd);
    check_state();
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    // 1. reset held for 200 ns
    #200;
    check_state();
    rst_n = 1'b1;

    // 2. fill with 0..255,0..255 and spot-check thresholds
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 8'(i), 1'b0);
      if (i == 4)         chk("ae_low_after_5th",   32'(almost_empty), 32'd0);
      if (i == AFN - 2)   chk("af_low_at_379",      32'(almost_full),  32'd0);
      if (i == AFN - 1)   chk("af_high_at_380",     32'(almost_full),  32'd1);
      if (i == DEPTH - 2) chk("full_low_at_511",    32'(full),         32'd0);
    end
    chk("full_after_512", 32'(full), 32'd1);
    step(1'b1, 8'hEE, 1'b0);

    // 3. drain, including reads past empty
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("drain_order", 32'(rd_data), 32'(i % 256));
    end
    chk("empty_after_drain", 32'(empty), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    chk("rd_hold_on_empty", 32'(rd_data), 32'd255);

    // 4. simultaneous read/write at occupancy 10
    for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 100; i++) step(1'b1, 8'($urandom), 1'b1);
    chk("steady_not_empty", 32'(empty), 32'd0);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);

    // 5. wrap: write 300, read 300, twice
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 300; i++) step(1'b1, 8'($urandom), 1'b0);
      for (int i = 0; i < 300; i++) step(1'b0, 8'h00, 1'b1);
    end

    // 6. async reset at occupancy 200, no clock edge needed
    for (int i = 0; i < 200; i++) step(1'b1, 8'($urandom), 1'b0);
    idle();
    rst_n = 1'b0;
    model_q.delete();
    exp_rd = '0;
    #2;
    check_state();
    #1;
    rst_n = 1'b1;
    step(1'b1, 8'hA5, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("post_reset_read", 32'(rd_data), 32'hA5);

    // random traffic: write-biased then read-biased to visit both ends
    for (int i = 0; i < 1200; i++)
      step($urandom_range(0, 99) < 75, 8'($urandom), $urandom_range(0, 99) < 35);
    for (int i = 0; i < 1200; i++)
      step($urandom_range(0, 99) < 30, 8'($urandom), $urandom_range(0, 99) < 70);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
